idp_decoder_37: RTL and testbench

IDP_DECODER_37 -- requirements
Module: idp_decoder_37

---
 rtl/idp_decoder_37.sv | 156 +++++++++++++++
 tb/tb_idp_decoder_37.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idp_decoder_37.sv
// IDP decoder: 37-bit codeword (MSB nibble + 33-bit Fibonacci field) to binary.
// Three-stage valid/ready pipeline with illegal-nibble / range flags and a saturating error count.
`ifndef IBLEN37
`define IBLEN37 26
`endif

module idp_decoder_37 #(
  parameter int unsigned ERRCNT_W = 16
) (
  input  logic                clock,
  input  logic                rst_n,
  input  logic [36:0]         codein,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [`IBLEN37-1:0] dataout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                err_nibble,
  output logic                err_range,
  output logic [ERRCNT_W-1:0] err_count,
  input  logic                clear_err
);
  localparam int unsigned DataW  = `IBLEN37;
  localparam logic [27:0] MaxVal = 28'((64'd1 << DataW) - 64'd1);

  function automatic logic [27:0] fns(input int unsigned n);
    logic [27:0] a, b, t;
    a = 28'd1;
    b = 28'd1;
    for (int unsigned k = 3; k <= n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  localparam logic [27:0] Fns34 = fns(34);
  localparam logic [27:0] Fns36 = fns(36);
  localparam logic [27:0] Fns37 = fns(37);

  logic              s1_valid_q, s2_valid_q, s3_valid_q;
  logic [32:0]       s1_code_q;
  logic [27:0]       s1_off_q;
  logic              s1_bad_q, s2_bad_q;
  logic [27:0]       s2_lo_q, s2_hi_q;
  logic [DataW-1:0]  s3_data_q;
  logic              s3_nib_q, s3_rng_q;
  logic [ERRCNT_W-1:0] err_cnt_q;

  logic        s1_adv, s2_adv, s3_adv;
  logic [27:0] off_d, lo_d, hi_d, sum_d;
  logic        bad_d;

  // Each stage may load when empty or when its occupant moves on this cycle.
  assign s3_adv   = !s3_valid_q || out_ready;
  assign s2_adv   = !s2_valid_q || s3_adv;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    off_d = '0;
    bad_d = 1'b0;
    case (codein[36:33])
      4'b0000: off_d = '0;
      4'b0001: off_d = Fns34;
      4'b1000: off_d = Fns36;
      4'b1001: off_d = Fns34 + Fns36;
      4'b0011: off_d = Fns34 + Fns37;
      4'b1100: off_d = Fns36 + Fns37;
      4'b0110: off_d = 2 * Fns37;
      4'b0111: off_d = 2 * Fns37 + Fns34;
      4'b1110: off_d = 2 * Fns37 + Fns36;
      4'b1111: off_d = 2 * Fns37 + Fns36 + Fns34;
      default: bad_d = 1'b1;
    endcase
  end

  always_comb begin
    lo_d = {27'd0, s1_code_q[0]};
    for (int unsigned i = 1; i <= 16; i++) begin
      if (s1_code_q[i]) lo_d = lo_d + fns(i + 1);
    end
    hi_d = s1_off_q;
    for (int unsigned i = 17; i <= 32; i++) begin
      if (s1_code_q[i]) hi_d = hi_d + fns(i + 1);
    end
    sum_d = s2_lo_q + s2_hi_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_off_q   <= '0;
      s1_bad_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_lo_q    <= '0;
      s2_hi_q    <= '0;
      s2_bad_q   <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_data_q  <= '0;
      s3_nib_q   <= 1'b0;
      s3_rng_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          s1_code_q <= codein[32:0];
          s1_off_q  <= off_d;
          s1_bad_q  <= bad_d;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_lo_q  <= lo_d;
          s2_hi_q  <= hi_d;
          s2_bad_q <= s1_bad_q;
        end
      end
      if (s3_adv) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          // Illegal nibble wins over range: zero data, no range flag.
          if (s2_bad_q) begin
            s3_data_q <= '0;
            s3_nib_q  <= 1'b1;
            s3_rng_q  <= 1'b0;
          end else if (sum_d > MaxVal) begin
            s3_data_q <= '1;
            s3_nib_q  <= 1'b0;
            s3_rng_q  <= 1'b1;
          end else begin
            s3_data_q <= sum_d[DataW-1:0];
            s3_nib_q  <= 1'b0;
            s3_rng_q  <= 1'b0;
          end
        end
      end
      if (clear_err) begin
        err_cnt_q <= '0;
      end else if (s3_valid_q && out_ready && (s3_nib_q || s3_rng_q) && !(&err_cnt_q)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  assign dataout    = s3_data_q;
  assign out_valid  = s3_valid_q;
  assign err_nibble = s3_nib_q;
  assign err_range  = s3_rng_q;
  assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_idp_decoder_37.sv
// Randomized bench for idp_decoder_37: arithmetic reference decoder, encoder for round trips,
// scoreboard with stall-stability and error-count tracking.
`timescale 1ns/1ps

module tb_idp_decoder_37;
  localparam int     DW   = 26;
  localparam int     CW   = 16;
  localparam longint MAXV = (64'd1 << DW) - 1;

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic [36:0]   codein = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dataout;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          err_nibble, err_range;
  logic [CW-1:0] err_count;
  logic          clear_err = 1'b0;

  always #5 clock = ~clock;

  idp_decoder_37 #(.ERRCNT_W(CW)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .codein    (codein),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dataout   (dataout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_nibble(err_nibble),
    .err_range (err_range),
    .err_count (err_count),
    .clear_err (clear_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  typedef struct {
    longint data;
    bit     en;
    bit     er;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] legal_nibs [10] = '{4'h0, 4'h1, 4'h8, 4'h9, 4'h3, 4'hC, 4'h6, 4'h7, 4'hE, 4'hF};
  bit         enc_phase = 1'b0;
  longint     cur_data = 0;

  function automatic longint fns(input int n);
    longint a = 1, b = 1, t;
    for (int k = 3; k <= n; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic void off_of(input logic [3:0] nib, output longint off, output bit legal);
    longint f34 = fns(34), f36 = fns(36), f37 = fns(37);
    legal = 1'b1;
    off   = 0;
    case (nib)
      4'b0000: off = 0;
      4'b0001: off = f34;
      4'b1000: off = f36;
      4'b1001: off = f34 + f36;
      4'b0011: off = f34 + f37;
      4'b1100: off = f36 + f37;
      4'b0110: off = 2 * f37;
      4'b0111: off = 2 * f37 + f34;
      4'b1110: off = 2 * f37 + f36;
      4'b1111: off = 2 * f37 + f36 + f34;
      default: legal = 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input logic [36:0] c);
    exp_t   e;
    longint off, s;
    bit     legal;
    off_of(c[36:33], off, legal);
    s = off + longint'(c[0]);
    for (int i = 1; i <= 32; i++) if (c[i]) s += fns(i + 1);
    e.en = !legal;
    e.er = 1'b0;
    e.data = 0;
    if (legal) begin
      if (s > MAXV) begin
        e.er = 1'b1;
        e.data = MAXV;
      end else e.data = s;
    end
    return e;
  endfunction

  // Pick the largest legal offset not above d, then greedy Fibonacci on the remainder.
  function automatic logic [36:0] encode(input longint d);
    longint best = 0, off, rem;
    bit legal;
    logic [3:0] bn = 4'h0;
    logic [36:0] c = '0;
    for (int k = 0; k < 10; k++) begin
      off_of(legal_nibs[k], off, legal);
      if (off <= d && off >= best) begin
        best = off;
        bn = legal_nibs[k];
      end
    end
    rem = d - best;
    c[36:33] = bn;
    for (int i = 32; i >= 1; i--) begin
      if (rem >= fns(i + 1)) begin
        c[i] = 1'b1;
        rem -= fns(i + 1);
      end
    end
    c[0] = (rem != 0);
    return c;
  endfunction

  function automatic logic [36:0] rand_code();
    logic [63:0] r;
    logic [36:0] c;
    r = {$urandom(), $urandom()};
    c = r[36:0];
    if ($urandom_range(1) == 1) c[36:33] = legal_nibs[$urandom_range(9)];
    return c;
  endfunction

  // Monitor: sampled on the falling edge, i.e. just before the transfer edge.
  longint        exp_cnt = 0;
  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_n, hold_r;

  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = 0;
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_data", dataout, hold_d);
        check_eq("stall_flags", {err_nibble, err_range}, {hold_n, hold_r});
      end
      check_eq("err_count", err_count, exp_cnt);
      if (in_valid && in_ready) begin
        if (enc_phase) begin
          e.data = cur_data;
          e.en = 1'b0;
          e.er = 1'b0;
        end else e = model(codein);
        exp_q.push_back(e);
      end
      if (clear_err) exp_cnt = 0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_out", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          check_eq("out_data", dataout, e.data);
          check_eq("out_err_nibble", err_nibble, e.en);
          check_eq("out_err_range", err_range, e.er);
          if (!clear_err && (e.en || e.er) && exp_cnt < (64'd1 << CW) - 1) exp_cnt++;
        end
      end
      hold_v = out_valid && !out_ready;
      hold_d = dataout;
      hold_n = err_nibble;
      hold_r = err_range;
    end
  end

  task automatic send_one(input string tag, input logic [36:0] code, input longint ed,
                          input bit en, input bit er);
    bit found = 1'b0;
    @(posedge clock); #1;
    codein = code;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clock);
      if (out_valid) found = 1'b1;
    end
    check_eq({tag, "_seen"}, found, 1);
    if (found) begin
      check_eq({tag, "_data"}, dataout, ed);
      check_eq({tag, "_flags"}, {err_nibble, err_range}, {en, er});
    end
  endtask

  task automatic run_stream(input int n, input bit enc, input int vprob, input int rprob);
    int sent = 0;
    int guard = 0;
    bit x;
    enc_phase = enc;
    in_valid = 1'b0;
    while (sent < n && guard < n * 40) begin
      if (!in_valid && $urandom_range(99) < vprob) begin
        if (enc) begin
          cur_data = longint'($urandom_range(0, 32'(MAXV)));
          codein = encode(cur_data);
        end else codein = rand_code();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(99) < rprob);
      @(negedge clock);
      x = in_valid && in_ready;
      @(posedge clock); #1;
      if (x) begin
        sent++;
        in_valid = 1'b0;
      end
      guard++;
    end
    check_eq("stream_sent", sent, n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clock);
    check_eq("drain", exp_q.size(), 0);
    @(posedge clock); #1;
    enc_phase = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [36:0] c;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_dataout", dataout, 0);
    check_eq("rst_flags", {err_nibble, err_range}, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clock); #1;
    rst_n = 1'b1;

    // Latency: present in cycle 0, out_valid only in cycle 3.
    @(posedge clock); #1;
    codein = '0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    check_eq("lat_in_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("lat_c1", out_valid, 0);
    @(negedge clock);
    check_eq("lat_c2", out_valid, 0);
    @(negedge clock);
    check_eq("lat_c3", out_valid, 1);
    check_eq("lat_data", dataout, 0);
    check_eq("lat_flags", {err_nibble, err_range}, 0);

    send_one("bit0", 37'h1, 1, 0, 0);
    send_one("bit32", 37'h1_0000_0000, 3524578, 0, 0);
    send_one("nib0001", {4'b0001, 33'h0}, 5702887, 0, 0);
    send_one("nib0110", {4'b0110, 33'h0}, 48315634, 0, 0);
    send_one("maxv", encode(MAXV), MAXV, 0, 0);
    send_one("range", {4'b1111, 33'h1_0000_0000}, MAXV, 0, 1);
    send_one("range_all", {4'b1110, {33{1'b1}}}, MAXV, 0, 1);
    send_one("nib1101", {4'b1101, {33{1'b1}}}, 0, 1, 0);
    @(posedge clock); #1;
    clear_err = 1'b1;
    @(posedge clock); #1;
    clear_err = 1'b0;

    send_one("nib0101", {4'b0101, 33'h0}, 0, 1, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("errcnt_one", err_count, 1);
    clear_err = 1'b1;
    send_one("clr_err", {4'b0010, 33'h5}, 0, 1, 0);
    @(posedge clock); #1;
    @(negedge clock);
    check_eq("errcnt_clear", err_count, 0);
    clear_err = 1'b0;

    run_stream(8, 1'b0, 100, 50);
    run_stream(400, 1'b0, 70, 60);

    // Reset with three words in flight.
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c = rand_code();
      codein = c;
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
    check_eq("full_out_valid", out_valid, 1);
    check_eq("full_in_ready", in_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_valid", out_valid, 0);
    check_eq("rst_mid_errcnt", err_count, 0);
    @(posedge clock); @(posedge clock); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      check_eq("post_rst_quiet", out_valid, 0);
    end

    run_stream(3000, 1'b1, 100, 75);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
